time_counters: RTL and testbench

TIME_COUNTERS -- requirements
Module: time_counters

---
 rtl/time_counters_pkg.sv | 24 ++
 rtl/time_counters_mod_counter.sv | 46 ++++
 rtl/time_counters.sv | 128 ++++++++++++
 tb/tb_time_counters.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/time_counters_pkg.sv
// -----------------------------------------------------------------------------
// time_counters_pkg
// Shared constants for the time-of-day counter block: field maxima, field
// widths and the bit positions of the per-field enable vector.
// No ports (package).
// -----------------------------------------------------------------------------
package time_counters_pkg;

    // Terminal values of each field (the value that wraps back to zero)
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    // Field widths
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    // Bit positions inside the 3-bit enable vector
    localparam int EN_SEC  = 0;
    localparam int EN_MIN  = 1;
    localparam int EN_HOUR = 2;

endpackage

// File: rtl/time_counters_mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
// Modulo-(MAX+1) up counter used for the seconds, minutes and hours fields.
//
// Ports
//   clock   : system clock, rising-edge active
//   reset_n : asynchronous active-low reset, forces value to 0
//   clear   : synchronous clear, wins over inc
//   inc     : advance by one on this edge (MAX wraps to 0)
//   value   : registered count, 0..MAX
//   carry   : high in the cycle where inc would wrap MAX -> 0
// -----------------------------------------------------------------------------
module mod_counter
    import time_counters_pkg::*;
#(
    parameter int MAX   = 59,
    parameter int WIDTH = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic at_max;

    assign at_max = (value == MAX_V);

    // A clear suppresses the wrap, so it must suppress the carry as well.
    assign carry = inc & ~clear & at_max;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            value <= '0;
        end else if (clear) begin
            value <= '0;
        end else if (inc) begin
            value <= at_max ? '0 : value + 1'b1;
        end
    end

endmodule

// File: rtl/time_counters.sv
// -----------------------------------------------------------------------------
// time_counters
// Hours/minutes/seconds time-of-day counter driven by a one-second prescaler,
// with per-field enables and a manual increment button for minutes/hours.
//
// Ports
//   i_Clock                     : system clock, rising-edge active
//   i_Reset_n                   : asynchronous active-low reset
//   i_Counters_Reset            : synchronous clear of seconds and prescaler
//   i_Counters_Enable_Increment : allows the manual button to increment
//   i_Counters_Enable_Count[2:0]: per-field enable (0 sec, 1 min, 2 hour)
//   i_Increment                 : debounced manual button level
//   o_Seconds[5:0]              : seconds 0..59
//   o_Minutes[5:0]              : minutes 0..59
//   o_Hours[4:0]                : hours 0..23
//   o_Tick                      : one-cycle pulse at prescaler terminal count
// -----------------------------------------------------------------------------
module time_counters
    import time_counters_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic        i_Clock,
    input  logic        i_Reset_n,
    input  logic        i_Counters_Reset,
    input  logic        i_Counters_Enable_Increment,
    input  logic [2:0]  i_Counters_Enable_Count,
    input  logic        i_Increment,
    output logic [5:0]  o_Seconds,
    output logic [5:0]  o_Minutes,
    output logic [4:0]  o_Hours,
    output logic        o_Tick
);

    localparam int              PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] prescaler;
    logic [PRE_W-1:0] prescaler_next;
    logic             inc_prev;
    logic             manual_pulse;
    logic             sec_inc;
    logic             min_inc;
    logic             hour_inc;
    logic             sec_carry;
    logic             min_carry;
    logic             hour_carry;

    assign prescaler_next = prescaler + 1'b1;

    // o_Tick is registered: it is loaded one edge early so that it is high
    // exactly while the prescaler holds its terminal value.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            prescaler <= '0;
            o_Tick    <= 1'b0;
        end else if (i_Counters_Reset) begin
            prescaler <= '0;
            o_Tick    <= 1'b0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            o_Tick    <= 1'b0;
        end else begin
            prescaler <= prescaler_next;
            o_Tick    <= (prescaler_next == PRE_LAST);
        end
    end

    // Previous button level resets to 1 so a button held through reset
    // release is not seen as a fresh press.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            inc_prev <= 1'b1;
        end else begin
            inc_prev <= i_Increment;
        end
    end

    assign manual_pulse = i_Increment & ~inc_prev & i_Counters_Enable_Increment;

    assign sec_inc  = o_Tick & i_Counters_Enable_Count[EN_SEC];
    assign min_inc  = i_Counters_Enable_Count[EN_MIN] & (sec_carry | manual_pulse);
    // A minutes wrap caused only by the button must not reach hours, so the
    // minutes carry is qualified by the seconds carry that caused it.
    assign hour_inc = i_Counters_Enable_Count[EN_HOUR]
                      & ((min_carry & sec_carry) | manual_pulse);

    mod_counter #(
        .MAX   (SEC_MAX),
        .WIDTH (SEC_W)
    ) u_seconds (
        .clock   (i_Clock),
        .reset_n (i_Reset_n),
        .clear   (i_Counters_Reset),
        .inc     (sec_inc),
        .value   (o_Seconds),
        .carry   (sec_carry)
    );

    mod_counter #(
        .MAX   (MIN_MAX),
        .WIDTH (MIN_W)
    ) u_minutes (
        .clock   (i_Clock),
        .reset_n (i_Reset_n),
        .clear   (1'b0),
        .inc     (min_inc),
        .value   (o_Minutes),
        .carry   (min_carry)
    );

    // Hours carry is unused: 23 -> 0 ends the chain.
    mod_counter #(
        .MAX   (HOUR_MAX),
        .WIDTH (HOUR_W)
    ) u_hours (
        .clock   (i_Clock),
        .reset_n (i_Reset_n),
        .clear   (1'b0),
        .inc     (hour_inc),
        .value   (o_Hours),
        .carry   (hour_carry)
    );

    logic unused_ok;
    assign unused_ok = hour_carry;

endmodule

// File: tb/tb_time_counters.sv
// -----------------------------------------------------------------------------
// tb_time_counters
// Directed bench for time_counters with TICK_DIV=4.
// -----------------------------------------------------------------------------
module tb_time_counters;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       counters_reset = 1'b0;
    logic       en_inc = 1'b0;
    logic [2:0] en_count = 3'b000;
    logic       incr = 1'b0;
    logic [5:0] seconds;
    logic [5:0] minutes;
    logic [4:0] hours;
    logic       tick;

    int n_cmp = 0;
    int n_bad = 0;

    time_counters #(
        .TICK_DIV (4)
    ) dut (
        .i_Clock                     (clk),
        .i_Reset_n                   (rst_n),
        .i_Counters_Reset            (counters_reset),
        .i_Counters_Enable_Increment (en_inc),
        .i_Counters_Enable_Count     (en_count),
        .i_Increment                 (incr),
        .o_Seconds                   (seconds),
        .o_Minutes                   (minutes),
        .o_Hours                     (hours),
        .o_Tick                      (tick)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance n rising edges, leaving time 1 unit past the last edge.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One button press: high for one edge, low for one edge.
    task automatic press(input int n);
        repeat (n) begin
            incr = 1'b1;
            step(1);
            incr = 1'b0;
            step(1);
        end
    endtask

    task automatic check_time(input string tag, input int s, input int m, input int h);
        check_val({tag, ".sec"}, int'(seconds), s);
        check_val({tag, ".min"}, int'(minutes), m);
        check_val({tag, ".hour"}, int'(hours), h);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // Power-on reset
        #1;
        rst_n = 1'b0;
        #2;
        check_time("reset", 0, 0, 0);
        check_val("reset.tick", int'(tick), 0);
        en_count = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;

        // Free run: tick high after edges 3,7,11,...
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check_val($sformatf("tick_pattern.e%0d", k), int'(tick), (k % 4 == 3) ? 1 : 0);
        end
        step(232);
        check_time("run240", 0, 1, 0);
        check_val("run240.tick", int'(tick), 0);

        // Manual minutes
        do_reset();
        en_count = 3'b010;
        en_inc   = 1'b1;
        step(1);
        press(3);
        check_time("man_min3", 0, 3, 0);
        press(57);
        check_time("man_min_wrap", 0, 0, 0);

        // Manual hours, full cycle
        en_count = 3'b100;
        press(5);
        check_val("man_hour5", int'(hours), 5);
        press(19);
        check_time("man_hour_wrap", 0, 0, 0);

        // Button held across enable transition
        en_inc = 1'b0;
        incr   = 1'b1;
        step(2);
        en_inc = 1'b1;
        step(2);
        check_val("held_button.hour", int'(hours), 0);
        incr = 1'b0;
        step(1);

        // Set 02:05, then seconds to 37
        press(2);
        en_count = 3'b010;
        press(5);
        check_time("preset_hm", 0, 5, 2);
        en_inc   = 1'b0;
        en_count = 3'b001;
        counters_reset = 1'b1;
        step(1);
        counters_reset = 1'b0;
        step(148);
        check_time("sec37", 37, 5, 2);
        step(2);
        check_val("sec37.hold", int'(seconds), 37);
        counters_reset = 1'b1;
        step(1);
        counters_reset = 1'b0;
        check_time("clear", 0, 5, 2);
        check_val("clear.tick0", int'(tick), 0);
        step(1);
        check_val("clear.tick1", int'(tick), 0);
        step(1);
        check_val("clear.tick2", int'(tick), 0);
        step(1);
        check_val("clear.tick3", int'(tick), 1);

        // Build 23:59:59
        en_inc   = 1'b1;
        en_count = 3'b100;
        press(21);
        en_count = 3'b010;
        press(54);
        en_inc   = 1'b0;
        en_count = 3'b001;
        counters_reset = 1'b1;
        step(1);
        counters_reset = 1'b0;
        step(236);
        check_time("pre_roll", 59, 59, 23);
        en_count = 3'b111;
        step(3);
        check_val("pre_roll.tick", int'(tick), 1);
        check_time("pre_roll.hold", 59, 59, 23);
        step(1);
        check_time("rollover", 0, 0, 0);

        // Mid-count async reset with button held
        step(4);
        check_val("midcount.sec", int'(seconds), 1);
        step(2);
        en_inc = 1'b1;
        incr   = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_time("async_rst", 0, 0, 0);
        check_val("async_rst.tick", int'(tick), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        check_time("rel_held", 0, 0, 0);
        check_val("rel_held.tick", int'(tick), 1);
        step(1);
        check_time("resume", 1, 0, 0);
        incr = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
